// File: rtl/serial_crc8_accumulator_if.sv
// Bit-serial frame in / CRC result out handshake bundle for serial_crc8_accumulator.
// The master side feeds bits and consumes results; the slave side is the accumulator.
interface serial_crc8_accumulator_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_crc;
   logic        out_ok;
   logic [15:0] out_len;

   modport master (
      output in_valid,
      output in_bit,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_crc,
      input  out_ok,
      input  out_len
   );

   modport slave (
      input  in_valid,
      input  in_bit,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_crc,
      output out_ok,
      output out_len
   );
endinterface

// File: rtl/serial_crc8_accumulator.sv
// Serial MSB-first CRC-8 accumulator: absorbs one bit per accepted transfer and
// holds the frame's CRC and bit count until the consumer takes the result.
module serial_crc8_accumulator #(
   parameter logic [7:0] POLY = 8'h07,
   parameter logic [7:0] INIT = 8'h00
) (
   input logic                    clk,
   input logic                    rst,
   serial_crc8_accumulator_if.slave bus
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state_p0;
   state_t      state_next;
   logic [7:0]  crc_p0;
   logic [7:0]  crc_next;
   logic [15:0] len_p0;
   logic [15:0] len_next;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // The HOLD->ACCUM handoff cycle keeps in_ready low, giving the one-cycle bubble.
   always_comb begin
      state_next    = state_p0;
      crc_next      = crc_p0;
      len_next      = len_p0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_p0)
         ACCUM: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               crc_next = crc8_step(crc_p0, bus.in_bit);
               len_next = sat_inc(len_p0);
               if (bus.in_last) begin
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = ACCUM;
               crc_next   = INIT;
               len_next   = 16'd0;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // Stage p0: frame state, running CRC and bit count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p0 <= ACCUM;
         crc_p0   <= INIT;
         len_p0   <= 16'd0;
      end else begin
         state_p0 <= state_next;
         crc_p0   <= crc_next;
         len_p0   <= len_next;
      end
   end

   assign bus.out_crc = crc_p0;
   assign bus.out_len = len_p0;
   assign bus.out_ok  = (crc_p0 == 8'h00);

endmodule

// File: tb/tb_serial_crc8_accumulator.sv
// Directed bench for serial_crc8_accumulator: known CRC-8 (poly 0x07) vectors,
// handshake stalls, async reset and bit-count saturation.
module tb_serial_crc8_accumulator;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   serial_crc8_accumulator_if bus ();

   serial_crc8_accumulator #(
      .POLY(8'h07),
      .INIT(8'h00)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input logic last);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 20) check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'bx;
      bus.in_last  = 1'bx;
   endtask

   task automatic send_byte(input logic [7:0] data, input logic last, input logic gaps);
      for (int i = 7; i >= 0; i--) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         send_bit(data[i], last && (i == 0));
      end
   endtask

   task automatic send_check_string(input logic gaps);
      logic [7:0] msg [9];
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      for (int k = 0; k < 9; k++) send_byte(msg[k], k == 8, gaps);
   endtask

   task automatic check_result(input string tag, input logic [7:0] crc,
                               input logic [15:0] len, input logic ok);
      check($sformatf("%s.out_valid", tag), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("%s.in_ready", tag), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("%s.out_crc", tag), {24'd0, bus.out_crc}, {24'd0, crc});
      check($sformatf("%s.out_len", tag), {16'd0, bus.out_len}, {16'd0, len});
      check($sformatf("%s.out_ok", tag), {31'd0, bus.out_ok}, {31'd0, ok});
   endtask

   task automatic consume(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check($sformatf("%s.drop_valid", tag), {31'd0, bus.out_valid}, 32'd0);
      check($sformatf("%s.reload_crc", tag), {24'd0, bus.out_crc}, 32'h00);
      check($sformatf("%s.clear_len", tag), {16'd0, bus.out_len}, 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'bx;
      bus.in_last   = 1'bx;
      bus.out_ready = 1'b0;

      #12;
      check("rst.out_crc", {24'd0, bus.out_crc}, 32'h00);
      check("rst.out_len", {16'd0, bus.out_len}, 32'd0);
      check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Single byte 0x80 -> table[0x80] = 0x89
      send_byte(8'h80, 1'b1, 1'b0);
      check_result("byte80", 8'h89, 16'd8, 1'b0);
      consume("byte80");

      // Standard CRC-8 check string
      send_check_string(1'b0);
      check_result("check_str", 8'hF4, 16'd72, 1'b0);
      consume("check_str");

      // Message 0x01 followed by its own CRC 0x07 leaves a zero residue
      send_byte(8'h01, 1'b0, 1'b0);
      send_byte(8'h07, 1'b1, 1'b0);
      check_result("residue", 8'h00, 16'd16, 1'b1);
      consume("residue");

      // Single-bit frames
      send_bit(1'b1, 1'b1);
      check_result("one_bit1", 8'h07, 16'd1, 1'b0);
      consume("one_bit1");
      send_bit(1'b0, 1'b1);
      check_result("one_bit0", 8'h00, 16'd1, 1'b1);
      consume("one_bit0");

      // Idle cycles in ACCUM change nothing
      send_bit(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("idle.out_crc", {24'd0, bus.out_crc}, 32'h07);
      check("idle.out_len", {16'd0, bus.out_len}, 32'd1);
      check("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);
      send_bit(1'b0, 1'b1);
      check_result("idle_end", 8'h0E, 16'd2, 1'b0);
      consume("idle_end");

      // Back-pressure on the result while the producer keeps offering a bit
      send_byte(8'h80, 1'b1, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      bus.in_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d.in_ready", c), {31'd0, bus.in_ready}, 32'd0);
         check($sformatf("stall%0d.out_valid", c), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("stall%0d.out_crc", c), {24'd0, bus.out_crc}, 32'h89);
         check($sformatf("stall%0d.out_len", c), {16'd0, bus.out_len}, 32'd8);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bubble.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("bubble.out_len", {16'd0, bus.out_len}, 32'd0);
      check("bubble.out_crc", {24'd0, bus.out_crc}, 32'h00);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("after_bubble.out_len", {16'd0, bus.out_len}, 32'd1);
      check("after_bubble.out_crc", {24'd0, bus.out_crc}, 32'h07);
      check("after_bubble.out_valid", {31'd0, bus.out_valid}, 32'd0);
      send_bit(1'b0, 1'b1);
      check_result("after_bubble_end", 8'h0E, 16'd2, 1'b0);
      consume("after_bubble_end");

      // Check string with random in_valid gaps
      send_check_string(1'b1);
      check_result("gaps", 8'hF4, 16'd72, 1'b0);
      consume("gaps");

      // Async reset mid-frame
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_mid.out_crc", {24'd0, bus.out_crc}, 32'h00);
      check("rst_mid.out_len", {16'd0, bus.out_len}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_bit(1'b1, 1'b0);
      check("post_rst_first.out_len", {16'd0, bus.out_len}, 32'd1);
      for (int i = 0; i < 7; i++) send_bit(1'b0, i == 6);
      check_result("post_rst80", 8'h89, 16'd8, 1'b0);

      // Async reset while a result is held
      #2;
      rst = 1'b1;
      #1;
      check("rst_hold.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_hold.out_crc", {24'd0, bus.out_crc}, 32'h00);
      check("rst_hold.out_len", {16'd0, bus.out_len}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h80, 1'b1, 1'b0);
      check_result("post_hold_rst80", 8'h89, 16'd8, 1'b0);
      consume("post_hold_rst80");

      // Bit count saturates at 0xFFFF
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b0;
      bus.in_last  = 1'b0;
      repeat (65540) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("sat.out_len", {16'd0, bus.out_len}, 32'h0000FFFF);
      check("sat.out_valid", {31'd0, bus.out_valid}, 32'd0);
      send_bit(1'b1, 1'b1);
      check_result("sat_end", 8'h07, 16'hFFFF, 1'b0);
      consume("sat_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/serial_crc8_accumulator.md
SERIAL_CRC8_ACCUMULATOR -- requirements
Module: serial_crc8_accumulator

Interface
REQ-001 The block SHALL have parameter POLY, default 8'h07, meaning the CRC-8 generator polynomial with the implicit x^8 term omitted.
REQ-002 The block SHALL have parameter INIT, default 8'h00, meaning the CRC register value at reset and at the start of each frame.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  in_bit and in_last are valid this cycle.
REQ-006 Port in_ready  output  1  block accepts a bit this cycle.
REQ-007 Port in_bit  input  1  serial data bit, MSB of each byte first.
REQ-008 Port in_last  input  1  accompanying bit is the final bit of the frame.
REQ-009 Port out_valid  output  1  frame result is presented.
REQ-010 Port out_ready  input  1  consumer takes the result this cycle.
REQ-011 Port out_crc  output  8  final CRC of the frame.
REQ-012 Port out_ok  output  1  high when out_crc == 8'h00, meaning the frame included a matching CRC.
REQ-013 Port out_len  output  16  number of bits accepted in the frame, saturating at 16'hFFFF.

Function
REQ-014 The block SHALL implement two states: ACCUM and HOLD.
REQ-015 The block SHALL drive in_ready = 1 in ACCUM and 0 in HOLD; out_valid SHALL be 1 in HOLD and 0 in ACCUM.
REQ-016 An input transfer SHALL occur when in_valid && in_ready are both high.
REQ-017 On each transfer: fb = crc[7] XOR in_bit; crc_next = {crc[6:0],1'b0} XOR (fb ? POLY : 8'h00).
REQ-018 On each transfer the bit count SHALL increment by 1, holding at 16'hFFFF once reached.
REQ-019 A transfer with in_last = 1 SHALL move ACCUM->HOLD; out_crc and out_len SHALL reflect that bit, and out_valid SHALL rise on the following cycle (1-cycle latency).
REQ-020 In HOLD, out_crc, out_ok and out_len SHALL remain stable until out_ready is sampled high.
REQ-021 In HOLD with out_ready = 1: the block SHALL return to ACCUM, reload crc to INIT and clear the count to 0; out_valid SHALL drop on the next cycle.
REQ-022 No input transfer SHALL occur in the same cycle as the HOLD->ACCUM handoff (one-cycle bubble); in_valid held across that cycle SHALL be accepted in the next cycle.
REQ-023 Cycles with in_valid = 0 in ACCUM SHALL leave crc and the count unchanged.
REQ-024 A single-bit frame (first accepted bit has in_last = 1) SHALL be legal and produce out_len = 1.
REQ-025 in_bit and in_last SHALL be ignored when no transfer occurs, including any X values.
REQ-026 out_ok SHALL be derived combinationally from the held CRC; out_crc and out_len SHALL come directly from registers.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for a clock edge, force: state ACCUM, crc = INIT, count = 0, out_valid = 0, in_ready = 1 after release.
REQ-028 out_crc SHALL read INIT and out_len SHALL read 0 while rst is high.
REQ-029 A reset asserted mid-frame or in HOLD SHALL discard the partial frame or unconsumed result with no output transfer.
REQ-030 The first edge after rst deasserts SHALL be able to accept a bit.

Verification
REQ-031 Send byte 8'h80 MSB-first with in_last on the 8th bit, out_ready = 1 -> out_crc = 8'h89, out_len = 8, out_ok = 0.
REQ-032 Send ASCII "123456789" (72 bits), in_last on the final bit -> out_crc = 8'hF4, out_len = 72.
REQ-033 Send 8'h01 then 8'h07 as one 16-bit frame -> out_crc = 8'h00, out_ok = 1, out_len = 16.
REQ-034 Hold out_ready = 0 for 5 cycles after a result while in_valid = 1 -> in_ready stays 0, out_* stable; raise out_ready -> exactly one output transfer, bubble cycle, then the next frame starts from INIT.
REQ-035 Random in_valid gaps during "123456789" -> same 8'hF4 result as the gap-free run.
REQ-036 Assert rst asynchronously after 4 bits of a frame and after a held result -> out_valid = 0 at once; a subsequent 8'h80 frame yields 8'h89.
